bcd_count_driver: RTL and testbench
===================================

BCD_COUNT_DRIVER -- requirements
Module: bcd_count_driver

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, SHALL set clock cycles per count tick (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 Parameter DEB_CYCLES, default 500_000, SHALL set the number of stable clock cycles a button needs before it is accepted; legal range 2..2^20.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 run_btn  input  1  raw, asynchronous, active-high pushbutton; toggles run/pause.
REQ-006 step_btn  input  1  raw, asynchronous, active-high pushbutton; single step while paused.
REQ-007 up  input  1  count direction: 1 = up, 0 = down; synchronous level.
REQ-008 load  input  1  synchronous strobe; loads load_val.
REQ-009 load_val  input  8  {tens, ones} BCD preset.
REQ-010 tens  output  4  BCD tens digit; feeds the tens-digit seven-segment decoder.
REQ-011 ones  output  4  BCD ones digit; feeds the ones-digit seven-segment decoder.
REQ-012 running  output  1  1 in RUN state.
REQ-013 wrap  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down).

Function
REQ-014 The FSM SHALL have exactly two states, PAUSE and RUN; a one-cycle debounced run_btn press pulse SHALL toggle the state.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and assert an internal tick on the cycle it reaches TICK_DIV-1, then return to 0.
REQ-016 The prescaler SHALL clear to 0 on entry to PAUSE and on load, so the first tick after resume is exactly TICK_DIV cycles after the toggle.
REQ-017 In RUN, each tick SHALL advance the count by one in the direction given by up at that cycle.
REQ-018 In PAUSE, each debounced step_btn press pulse SHALL advance the count by one; step pulses in RUN SHALL be ignored.
REQ-019 Up count: ones 9->0 with tens+1, and 99->00 with wrap=1 for that cycle.
REQ-020 Down count: ones 0->9 with tens-1, and 00->99 with wrap=1 for that cycle.
REQ-021 A load SHALL set tens/ones on the next edge; any nibble >9 SHALL be clamped to 9; wrap SHALL stay 0.
REQ-022 Priority SHALL be rst > load > count advance; simultaneous load and tick or step SHALL load and discard the advance.
REQ-023 A run_btn toggle and a tick in the same cycle SHALL apply the tick, then change state.
REQ-024 tens, ones, running and wrap SHALL be registered, with no combinational path from any input.
REQ-025 Each button conditioner SHALL use a 2-flop synchroniser and a counter requiring DEB_CYCLES consecutive equal samples before updating the stable level.
REQ-026 Each button conditioner SHALL emit a one-cycle pulse on a stable-level 0->1 transition only; a held button SHALL produce one pulse.
REQ-027 tens and ones SHALL never hold a value >9.

Reset
REQ-028 On rst: tens=0, ones=0, running=0, wrap=0, state=PAUSE.
REQ-029 On rst: prescaler=0, debounce counters=0, synchronisers=0, stable levels=0.
REQ-030 rst asserted mid-count or mid-debounce SHALL abort the operation with no pulse emitted after reset.
REQ-031 A button held through reset release SHALL produce exactly one pulse after DEB_CYCLES.

Structure
REQ-032 A shared package SHALL hold the state enum (PAUSE, RUN), the BCD digit width constant (4) and the BCD maximum constant (9).
REQ-033 One sub-module, btn_conditioner (synchroniser, debounce, rising-edge pulse; parameter DEB_CYCLES), SHALL be instantiated twice.
REQ-034 The prescaler, FSM and BCD counter SHALL reside in bcd_count_driver.

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-035 Reset then press run_btn: running=1 after debounce; up=1; ones steps 0,1,2 every 4 cycles.
REQ-036 load 8'h98, up=1, RUN: count goes 98->99->00, wrap=1 for exactly one cycle at 00.
REQ-037 load 8'h00, up=0, RUN: next tick gives 99 with wrap=1; next tick gives 98 with wrap=0.
REQ-038 PAUSE: step_btn held 20 cycles gives exactly one increment; a 2-cycle glitch gives none; step in RUN changes nothing beyond ticks.
REQ-039 load 8'hFA gives 99; load asserted on a tick cycle keeps the loaded value with no increment.
REQ-040 rst asserted mid-RUN at 47: the next cycle shows 00, running=0, wrap=0, and no tick follows.

Source files
------------

// File: rtl/bcd_count_driver_pkg.sv
// Shared types and constants for the two-digit BCD count driver.
package bcd_count_driver_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Saturate a preset nibble so a digit register never holds a non-BCD code.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_count_driver_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce filter and rising-edge pulse.
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Stable level flips only after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_count_driver.sv
// Two-digit BCD up/down counter with run/pause FSM, tick prescaler and debounced buttons.
module bcd_count_driver
    import bcd_count_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_btn,
    input  logic               step_btn,
    input  logic               up,
    input  logic               load,
    input  logic [7:0]         load_val,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               running,
    output logic               wrap
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state;
    logic [PRE_W-1:0] presc;
    logic             run_pulse;
    logic             step_pulse;
    logic             tick_c;
    logic             advance_c;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (run_btn),
        .pulse (run_pulse)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    assign tick_c    = (state == RUN) && (presc == PRE_LAST);
    assign advance_c = tick_c || ((state == PAUSE) && step_pulse);

    // A tick coinciding with a run toggle is applied before the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PAUSE;
            presc   <= '0;
            tens    <= '0;
            ones    <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;

            if (load || (state == PAUSE) || run_pulse || tick_c) begin
                presc <= '0;
            end else begin
                presc <= presc + PRE_W'(1);
            end

            if (run_pulse) begin
                state   <= (state == RUN) ? PAUSE : RUN;
                running <= (state == PAUSE);
            end

            if (load) begin
                tens <= bcd_clamp(load_val[7:4]);
                ones <= bcd_clamp(load_val[3:0]);
            end else if (advance_c) begin
                if (up) begin
                    if (ones == BCD_MAX) begin
                        ones <= '0;
                        if (tens == BCD_MAX) begin
                            tens <= '0;
                            wrap <= 1'b1;
                        end else begin
                            tens <= tens + DIGIT_W'(1);
                        end
                    end else begin
                        ones <= ones + DIGIT_W'(1);
                    end
                end else begin
                    if (ones == '0) begin
                        ones <= BCD_MAX;
                        if (tens == '0) begin
                            tens <= BCD_MAX;
                            wrap <= 1'b1;
                        end else begin
                            tens <= tens - DIGIT_W'(1);
                        end
                    end else begin
                        ones <= ones - DIGIT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_driver.sv
// Scoreboard bench for bcd_count_driver: a per-cycle reference model feeds a queue drained by a monitor.
module tb_bcd_count_driver;

    localparam int unsigned TD = 4;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       wrap;

    always #5 clk = ~clk;

    bcd_count_driver #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .tens     (tens),
        .ones     (ones),
        .running  (running),
        .wrap     (wrap)
    );

    typedef struct {
        int t;
        int o;
        bit r;
        bit w;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: count as an integer 0..99, button history windows.
    int  m_val = 0;
    bit  m_run = 0;
    bit  m_wrap = 0;
    int  m_elapsed = 0;
    bit  p1[2];
    bit  p2[2];
    bit  stab[2];
    bit  pls[2];
    bit  hist[2][$];

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    always @(posedge clk) begin
        bit raw[2];
        bit run_p;
        bit step_p;
        bit tick;
        bit seen;
        bit same;
        raw[0] = run_btn;
        raw[1] = step_btn;
        if (rst) begin
            m_val = 0; m_run = 0; m_wrap = 0; m_elapsed = 0;
            for (int b = 0; b < 2; b++) begin
                p1[b] = 0; p2[b] = 0; stab[b] = 0; pls[b] = 0;
                hist[b].delete();
            end
        end else begin
            run_p  = pls[0];
            step_p = pls[1];
            tick   = m_run && ((m_elapsed % TD) == TD - 1);
            m_wrap = 0;
            if (load) begin
                m_val = clamp9(load_val[7:4]) * 10 + clamp9(load_val[3:0]);
            end else if (tick || (!m_run && step_p)) begin
                if (up) begin
                    m_val  = (m_val + 1) % 100;
                    m_wrap = (m_val == 0);
                end else begin
                    m_val  = (m_val + 99) % 100;
                    m_wrap = (m_val == 99);
                end
            end
            // elapsed = RUN cycles since the last resume or load
            if (load || !m_run || run_p) m_elapsed = 0;
            else m_elapsed = m_elapsed + 1;
            if (run_p) m_run = !m_run;
            for (int b = 0; b < 2; b++) begin
                seen  = p2[b];
                p2[b] = p1[b];
                p1[b] = raw[b];
                hist[b].push_back(seen);
                if (hist[b].size() > DB) void'(hist[b].pop_front());
                pls[b] = 0;
                if (hist[b].size() == DB) begin
                    same = 1;
                    foreach (hist[b][i]) if (hist[b][i] != hist[b][0]) same = 0;
                    if (same && hist[b][0] != stab[b]) begin
                        stab[b] = hist[b][0];
                        pls[b]  = stab[b];
                    end
                end
            end
        end
        sb.push_back('{m_val / 10, m_val % 10, m_run, m_wrap});
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("tens",    8'(tens),    8'(e.t));
            chk("ones",    8'(ones),    8'(e.o));
            chk("running", 8'(running), 8'(e.r));
            chk("wrap",    8'(wrap),    8'(e.w));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        // start running and count up from reset
        up = 1'b1;
        run_btn = 1'b1;
        cyc(6);
        run_btn = 1'b0;
        cyc(14);
        // up wrap 98 -> 99 -> 00
        do_load(8'h98);
        cyc(14);
        // down wrap 00 -> 99 -> 98
        up = 1'b0;
        do_load(8'h00);
        cyc(12);
        // pause, long step press, short glitch
        up = 1'b1;
        run_btn = 1'b1; cyc(5); run_btn = 1'b0; cyc(6);
        step_btn = 1'b1; cyc(20); step_btn = 1'b0; cyc(8);
        step_btn = 1'b1; cyc(2); step_btn = 1'b0; cyc(8);
        // resume, step presses ignored while running
        run_btn = 1'b1; cyc(5); run_btn = 1'b0; cyc(4);
        step_btn = 1'b1; cyc(20); step_btn = 1'b0; cyc(8);
        // clamp, and loads landing on tick cycles
        do_load(8'hFA);
        cyc(3);
        for (int i = 0; i < 6; i++) do_load(8'(i * 8'h11));
        cyc(6);
        // reset in the middle of a run
        do_load(8'h47);
        cyc(5);
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(10);
        // button held through reset release
        run_btn = 1'b1;
        rst = 1'b1; cyc(2); rst = 1'b0;
        cyc(10);
        run_btn = 1'b0;
        cyc(8);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 5) == 0) run_btn = ~run_btn;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            cyc(1);
        end
        rst = 1'b0; load = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
        cyc(2);
        @(negedge clk);
        #1;
        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
